// File: rtl/spm_loader_pkg.sv
// Shared definitions for the RISC_SPM program loader: loader states,
// default word width and the word counter width/saturation limit.
package spm_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5
  } loader_state_t;

  localparam int DEFAULT_WORD_SIZE = 8;

  localparam int WORD_COUNT_W = 9;
  localparam logic [WORD_COUNT_W-1:0] WORD_COUNT_MAX = 9'd511;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spm_phase_counter.sv
// Loadable down-counter with a zero flag. The loader loads it with
// (phase length - 1) on entry to a timed phase and leaves the phase
// when the flag is set.
module spm_phase_counter
  import spm_loader_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spm_program_loader.sv
// Boot sequencer for RISC_SPM: accepts (address, data) words from a host,
// writes them through the processor's external memory port with timed
// setup/strobe phases, holds the processor in reset during the load and
// then releases it to run. A reload request from RUN returns to loading.
// Optional feature macro: SPM_LOADER_CHECKSUM_EN adds a running data
// checksum output and its valid flag.
module spm_program_loader
  import spm_loader_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 2,
  parameter int RST_HOLD     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [WORD_SIZE-1:0]    host_addr,
  input  logic [WORD_SIZE-1:0]    host_data,
  input  logic                    host_last,
  input  logic                    go,
  input  logic                    reload,
  output logic [WORD_SIZE-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0]    mem_data,
  output logic                    mem_we,
  output logic                    cpu_rst_n,
  output logic                    running,
  output logic [WORD_COUNT_W-1:0] word_count
`ifdef SPM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]    checksum,
  output logic                    checksum_valid
`endif
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, WE_CYCLES, RST_HOLD);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  loader_state_t state;
  logic          last_q;
  logic          handshake;
  logic          cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic          cnt_zero;

  assign host_ready = (state == ST_IDLE);
  assign handshake  = host_valid && host_ready;

  spm_phase_counter #(
    .WIDTH(CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(cnt_value),
    .zero      (cnt_zero)
  );

  // Load the shared counter with the length of whichever timed phase is next.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(SETUP_CYCLES - 1);
        end else if (go) begin
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(RST_HOLD - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(WE_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (last_q) begin
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(RST_HOLD - 1);
        end
      end
      default: begin
        cnt_load  = 1'b0;
        cnt_value = '0;
      end
    endcase
  end

  // Loader FSM; every memory-port and processor-control output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      cpu_rst_n  <= 1'b0;
      running    <= 1'b0;
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            mem_addr <= host_addr;
            mem_data <= host_data;
            last_q   <= host_last;
            state    <= ST_SETUP;
          end else if (go) begin
            state <= ST_RELEASE;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            mem_we <= 1'b1;
            state  <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            mem_we <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (word_count != WORD_COUNT_MAX) begin
            word_count <= word_count + 1'b1;
          end
          state <= last_q ? ST_RELEASE : ST_IDLE;
        end
        ST_RELEASE: begin
          if (cnt_zero) begin
            cpu_rst_n <= 1'b1;
            running   <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (reload) begin
            cpu_rst_n  <= 1'b0;
            running    <= 1'b0;
            word_count <= '0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPM_LOADER_CHECKSUM_EN
  // Accumulate every written data word; cleared when a new load begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == ST_HOLD) begin
      checksum <= checksum + mem_data;
    end else if (state == ST_RUN && reload) begin
      checksum <= '0;
    end
  end

  assign checksum_valid = (state == ST_RELEASE) || (state == ST_RUN);
`endif

endmodule

// File: tb/tb_spm_program_loader.sv
// Testbench for spm_program_loader (default parameters). Build with
// SPM_LOADER_CHECKSUM_EN defined to also cover the checksum outputs.
module tb_spm_program_loader;

  localparam int SETUP_C = 1;
  localparam int WE_C    = 2;
  localparam int HOLD_C  = 4;
  localparam int WORD_P  = SETUP_C + WE_C + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [7:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       host_last = 1'b0;
  logic       go = 1'b0;
  logic       reload = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_rst_n;
  logic       running;
  logic [8:0] word_count;
`ifdef SPM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       checksum_valid;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] obs_addr[$];
  logic [7:0] obs_data[$];
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic       we_prev = 1'b0;

  spm_program_loader dut (
    .clk       (clk),
    .rst       (rst),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_last (host_last),
    .go        (go),
    .reload    (reload),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .cpu_rst_n (cpu_rst_n),
    .running   (running),
    .word_count(word_count)
`ifdef SPM_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum),
    .checksum_valid(checksum_valid)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter for measuring acceptance spacing.
  always @(posedge clk) cyc++;

  // Record each write strobe (one entry per rising mem_we) as the processor memory would see it.
  always @(negedge clk) begin
    if (mem_we && !we_prev) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_data);
    end
    we_prev = mem_we;
  end

  task automatic do_reset();
    host_valid = 0; host_last = 0; go = 0; reload = 0;
    host_addr = 0; host_data = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  // Offers one word and returns on the negedge after it is taken (cycle 1 of the write).
  task automatic send_word(input logic [7:0] a, input logic [7:0] d, input logic l);
    int waited = 0;
    host_addr = a; host_data = d; host_last = l; host_valid = 1;
    while (!host_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!host_ready) begin
      miscompares++;
      $display("[TB] FAIL send_word_timeout: host_ready got %b after %0d cycles, required 1", host_ready, waited);
    end
    @(negedge clk);
    host_valid = 0; host_last = 0;
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic wait_running(input string tag);
    int waited = 0;
    while (!running && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!running) begin
      miscompares++;
      $display("[TB] FAIL %s_run_timeout: running got %b, required 1", tag, running);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (host_ready !== 1'b1 || mem_we !== 1'b0 || cpu_rst_n !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: ready/we/rst_n/run got %b%b%b%b, required 1000", host_ready, mem_we, cpu_rst_n, running);
    end
    vectors++;
    if (mem_addr !== 8'h00 || mem_data !== 8'h00 || word_count !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: addr %h data %h count %0d, required 00 00 0", mem_addr, mem_data, word_count);
    end
    send_word(8'($urandom), 8'($urandom), 1'b0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_prestrobe: mem_we got %b, required 1", mem_we);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || cpu_rst_n !== 1'b0 || host_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_async: we/rst_n/ready got %b%b%b, required 001", mem_we, cpu_rst_n, host_ready);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single_write();
    logic exp_we;
    do_reset();
    send_word(8'hF0, 8'h07, 1'b0);
    vectors++;
    if (mem_addr !== 8'hF0 || mem_data !== 8'h07 || mem_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_latch: addr %h data %h we %b, required F0 07 0", mem_addr, mem_data, mem_we);
    end
    for (int c = 2; c <= WORD_P; c++) begin
      @(negedge clk);
      exp_we = (c >= SETUP_C + 1) && (c <= SETUP_C + WE_C);
      vectors++;
      if (mem_we !== exp_we || host_ready !== (c == WORD_P)) begin
        miscompares++;
        $display("[TB] FAIL single_cycle%0d: we %b ready %b, required %b %b", c, mem_we, host_ready, exp_we, (c == WORD_P));
      end
    end
    vectors++;
    if (word_count !== 9'd1) begin
      miscompares++;
      $display("[TB] FAIL single_count: word_count got %0d, required 1", word_count);
    end
  endtask

  task automatic test_program();
    logic [7:0] pa[7] = '{8'h00, 8'hF0, 8'h01, 8'h02, 8'hF1, 8'h03, 8'h04};
    logic [7:0] pd[7] = '{8'h00, 8'h07, 8'h50, 8'hF0, 8'h03, 8'h51, 8'hF1};
    logic exp_run;
    do_reset();
    for (int i = 0; i < 7; i++) send_word(pa[i], pd[i], i == 6);
    for (int c = 2; c <= WORD_P + HOLD_C + 1; c++) begin
      @(negedge clk);
      exp_run = (c >= WORD_P + HOLD_C);
      vectors++;
      if (running !== exp_run || cpu_rst_n !== exp_run) begin
        miscompares++;
        $display("[TB] FAIL program_release_c%0d: running %b cpu_rst_n %b, required %b", c, running, cpu_rst_n, exp_run);
      end
    end
    vectors++;
    if (obs_addr != exp_addr || obs_data != exp_data || word_count !== 9'd7) begin
      miscompares++;
      $display("[TB] FAIL program_writes: %0d writes count %0d, required %0d writes count 7", obs_addr.size(), word_count, exp_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int idx = 0;
    int acc[$];
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] sum = 0;
    do_reset();
    n = $urandom_range(4, 10);
    for (int i = 0; i < n; i++) begin
      wa.push_back(8'($urandom));
      wd.push_back(8'($urandom));
      exp_addr.push_back(wa[i]);
      exp_data.push_back(wd[i]);
      sum += wd[i];
    end
    host_addr = wa[0]; host_data = wd[0]; host_last = (n == 1); host_valid = 1;
    for (int k = 0; k < 400 && idx < n; k++) begin
      if (host_ready) begin
        acc.push_back(cyc);
        idx++;
        @(negedge clk);
        if (idx < n) begin
          host_addr = wa[idx]; host_data = wd[idx]; host_last = (idx == n - 1);
        end else begin
          host_addr = 8'($urandom); host_data = 8'($urandom); host_last = 0;
        end
      end else begin
        @(negedge clk);
      end
    end
    wait_running("b2b");
    for (int i = 1; i < acc.size(); i++) begin
      vectors++;
      if (acc[i] - acc[i-1] != WORD_P) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, acc[i] - acc[i-1], WORD_P);
      end
    end
    repeat (8) begin
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b0 || host_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL run_ignores_host: we %b ready %b, required 0 0", mem_we, host_ready);
      end
    end
    vectors++;
    if (obs_addr != exp_addr || obs_data != exp_data || word_count !== 9'(n)) begin
      miscompares++;
      $display("[TB] FAIL b2b_writes: %0d writes count %0d, required %0d", obs_addr.size(), word_count, n);
    end
`ifdef SPM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum !== sum || checksum_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_checksum: got %h valid %b, required %h 1", checksum, checksum_valid, sum);
    end
`endif
    host_valid = 0;
    reload = 1;
    @(negedge clk);
    reload = 0;
    vectors++;
    if (host_ready !== 1'b1 || cpu_rst_n !== 1'b0 || running !== 1'b0 || word_count !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reload: ready %b rst_n %b run %b count %0d, required 1 0 0 0", host_ready, cpu_rst_n, running, word_count);
    end
`ifdef SPM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum !== 8'h00 || checksum_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reload_checksum: got %h valid %b, required 00 0", checksum, checksum_valid);
    end
`endif
  endtask

  task automatic test_go();
    logic exp_run;
    do_reset();
    reload = 1;
    go = 1;
    @(negedge clk);
    go = 0; reload = 0;
    for (int c = 1; c <= HOLD_C + 2; c++) begin
      exp_run = (c >= HOLD_C + 1);
      vectors++;
      if (running !== exp_run || cpu_rst_n !== exp_run || word_count !== 9'd0) begin
        miscompares++;
        $display("[TB] FAIL go_c%0d: running %b rst_n %b count %0d, required %b %b 0", c, running, cpu_rst_n, word_count, exp_run, exp_run);
      end
      @(negedge clk);
    end
    host_valid = 1; go = 1;
    repeat (6) begin
      host_addr = 8'($urandom); host_data = 8'($urandom);
      @(negedge clk);
    end
    host_valid = 0; go = 0;
    vectors++;
    if (obs_addr.size() != 0 || running !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL go_run_writes: %0d writes running %b, required 0 writes running 1", obs_addr.size(), running);
    end
    // go together with data: the word wins and go is ignored.
    do_reset();
    host_addr = 8'h3C; host_data = 8'hA5; host_valid = 1; go = 1;
    @(negedge clk);
    host_valid = 0; go = 0;
    repeat (WORD_P - 1) @(negedge clk);
    vectors++;
    if (host_ready !== 1'b1 || running !== 1'b0 || word_count !== 9'd1 || mem_addr !== 8'h3C || mem_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL go_with_data: ready %b run %b count %0d addr %h data %h, required 1 0 1 3C A5", host_ready, running, word_count, mem_addr, mem_data);
    end
  endtask

  task automatic test_random_program();
    int n;
    logic [7:0] sum = 0;
    logic [7:0] d;
    do_reset();
    n = $urandom_range(3, 12);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom);
      sum += d;
      send_word(8'($urandom_range(0, 7)), d, i == n - 1);
    end
    wait_running("random");
    vectors++;
    if (obs_addr != exp_addr || obs_data != exp_data || word_count !== 9'(n)) begin
      miscompares++;
      $display("[TB] FAIL random_writes: %0d writes count %0d, required %0d", obs_addr.size(), word_count, n);
    end
`ifdef SPM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum !== sum) begin
      miscompares++;
      $display("[TB] FAIL random_checksum: got %h, required %h", checksum, sum);
    end
`endif
  endtask

  task automatic test_checksum();
`ifdef SPM_LOADER_CHECKSUM_EN
    do_reset();
    send_word(8'hF0, 8'h07, 1'b0);
    send_word(8'hF1, 8'h03, 1'b0);
    send_word(8'h04, 8'hF1, 1'b1);
    wait_running("checksum");
    vectors++;
    if (checksum !== 8'hFB || checksum_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL checksum_fb: got %h valid %b, required FB 1", checksum, checksum_valid);
    end
`endif
  endtask

  task automatic test_saturation();
    int accepted = 0;
    int expected;
    do_reset();
    host_valid = 1; host_last = 0;
    for (int k = 0; k < 4000 && accepted < 515; k++) begin
      host_addr = 8'($urandom); host_data = 8'($urandom);
      if (host_ready) accepted++;
      @(negedge clk);
    end
    host_valid = 0;
    repeat (WORD_P + 1) @(negedge clk);
    expected = (accepted > 511) ? 511 : accepted;
    vectors++;
    if (word_count !== 9'(expected)) begin
      miscompares++;
      $display("[TB] FAIL saturation: word_count got %0d, required %0d", word_count, expected);
    end
  endtask

  initial begin
    $display("[TB] spm_program_loader bench start");
    test_reset();
    test_single_write();
    test_program();
    test_back_to_back();
    test_go();
    test_random_program();
    test_checksum();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spm_program_loader.md
Name: spm_program_loader

Overview:
- Boot sequencer and memory-port owner for the RISC_SPM processor.
- Accepts (address, data) program words from a host over a valid/ready handshake.
- Drives the processor's external memory-write port (address_bus, data_bus, ext_write) with timed setup and strobe phases.
- Holds the processor in reset for the whole load, then releases it to run; it can re-enter load on request.

Parameters:
- WORD_SIZE, 8, width of address and data words.
- SETUP_CYCLES, 1, cycles that address/data are stable before the write strobe (>=1).
- WE_CYCLES, 2, width of the ext_write pulse in cycles (>=1).
- RST_HOLD, 4, cycles the processor reset stays asserted after the final write (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- host_valid  in  1  host offers a program word
- host_ready  out  1  loader accepts a word this cycle
- host_addr  in  WORD_SIZE  target memory address
- host_data  in  WORD_SIZE  word to write
- host_last  in  1  qualifies the final word of the program
- go  in  1  start the processor with no further words
- reload  in  1  return from RUN to load mode
- mem_addr  out  WORD_SIZE  to processor address_bus
- mem_data  out  WORD_SIZE  to processor data_bus
- mem_we  out  1  to processor ext_write
- cpu_rst_n  out  1  processor reset, active-low
- running  out  1  high in RUN
- word_count  out  9  words written since the last reset/reload

Behaviour:
- States: IDLE, SETUP, STROBE, HOLD, RELEASE, RUN. One shared down-counter times SETUP, STROBE and RELEASE.
- Reset (async, rst=1) values:
  - state=IDLE
  - mem_addr=0, mem_data=0, mem_we=0
  - cpu_rst_n=0, running=0, word_count=0
  - host_ready=1, since it is a decode of state==IDLE
- IDLE:
  - Handshake fires on a rising edge with host_valid & host_ready.
  - On that edge: latch host_addr/host_data into mem_addr/mem_data, latch host_last into last_q, go to SETUP.
  - If go=1 and host_valid=0: go to RELEASE. If host_valid=1, go is ignored.
- SETUP: mem_we=0 for SETUP_CYCLES, then STROBE.
- STROBE: mem_we=1 for exactly WE_CYCLES, then HOLD.
- HOLD: one cycle, mem_we=0, addr/data still held; word_count increments, saturating at 511. Next state is RELEASE if last_q, else IDLE.
- Timing with defaults: handshake at edge 0 gives mem_we high in cycles 2–3, HOLD in cycle 4, host_ready high again in cycle 5. Per-word period is SETUP_CYCLES+WE_CYCLES+2.
- RELEASE: cpu_rst_n=0 for RST_HOLD cycles, then RUN.
- RUN:
  - cpu_rst_n=1, running=1, host_ready=0; mem_we stays 0 and mem_addr/mem_data hold their last values.
  - host_valid and go are ignored.
  - reload=1 gives, on the next edge: state IDLE, cpu_rst_n=0, running=0, word_count=0.
- reload outside RUN is ignored.
- cpu_rst_n, mem_we and running are registered outputs (glitch-free).
- Address rules: repeated addresses are permitted (last write wins); no address range check.
- Reset mid-write forces mem_we=0 immediately (asynchronous). The partial write is lost, and the host must resend the whole program.

Optional Feature:
- Macro: SPM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[WORD_SIZE-1:0]: the modulo-2^WORD_SIZE sum of every data word written, updated in HOLD.
  - checksum is cleared by rst and by reload.
  - Adds output checksum_valid, high in RELEASE and RUN.
- When undefined: neither port nor its adder exists; all other behaviour is identical.

Decomposition:
- Package spm_loader_pkg holds:
  - the state enumeration;
  - the default WORD_SIZE;
  - the word_count width constant (9) and its saturation value (511).
- One sub-module: spm_phase_counter, a loadable down-counter with a zero flag. It is used for SETUP, STROBE and RELEASE timing.

Test Plan:
- Reset: assert rst mid-STROBE -> mem_we=0, cpu_rst_n=0, host_ready=1 without waiting for a clock edge.
- Single write: (addr 8'hF0, data 8'h07, last=0) at edge 0 -> mem_addr=F0 and mem_data=07 from cycle 1, mem_we=1 in cycles 2–3 only, host_ready=1 at cycle 5, word_count=1.
- Seven-word program: the RISC_SPM bring-up sequence below, with last on word 7 -> mem_we pulses land at each address exactly once, and RELEASE holds cpu_rst_n=0 for 4 cycles before running=1.
  - 00:00, F0:07, 01:50, 02:F0, F1:03, 03:51, 04:F1.
- Back-pressure: hold host_valid=1 continuously -> exactly one word is accepted every 5 cycles, with no duplicated or dropped words.
- go without data from IDLE -> RUN after 4 RELEASE cycles with word_count=0. go asserted together with host_valid -> the word is written and go is ignored.
- RUN/reload: in RUN, host_valid=1 -> no mem_we. A reload pulse -> next cycle IDLE, cpu_rst_n=0, word_count=0. With SPM_LOADER_CHECKSUM_EN, words 07, 03, F1 -> checksum=8'hFB.
